mux_pipe_stage: RTL and testbench
=================================

# mux_pipe_stage

Parametrised N-way, WIDTH-bit registered select stage for the MIPS datapath. It generalises the plain 2:1 select used for destination-register and operand choice. It picks one of NUM_IN input channels per transfer, registers the result, and hands it downstream over a valid/ready handshake. A one-entry skid buffer sustains full throughput under back-pressure, and a synchronous flush supports pipeline squash on branch/exception.

## Interface
Parameters:
- WIDTH, 5: data bits per channel.
- NUM_IN, 4: number of input channels (≥2).
- SEL_W, 2: select width; must satisfy 2^SEL_W ≥ NUM_IN.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- data_in  input  NUM_IN*WIDTH  flattened channels; channel i = data_in[i*WIDTH +: WIDTH].
- sel  input  SEL_W  channel select, sampled with in_valid.
- in_valid  input  1  upstream offers a transfer this cycle.
- in_ready  output  1  stage can accept; registered, depends only on state.
- out_data  output  WIDTH  selected data of the head entry.
- out_sel  output  SEL_W  effective channel index of the head entry.
- out_valid  output  1  head entry valid.
- out_ready  input  1  downstream accepts head entry this cycle.
- flush  input  1  synchronous squash of all held entries.
- sel_err  output  1  sticky flag: an out-of-range select was accepted.
- err_clr  input  1  clears sel_err.

## Operation
- Storage: head register (out_data/out_sel/out_valid) plus one skid entry (skid_data/skid_sel/skid_valid).
- Accept = in_valid && in_ready. Pop = out_valid && out_ready.
- Select rule: sel < NUM_IN picks channel sel. sel ≥ NUM_IN picks channel 0, stores effective index 0 in out_sel, and sets sel_err.
- State by (out_valid, skid_valid): EMPTY (0,0), ONE (1,0), FULL (1,1). (0,1) is unreachable.
- EMPTY: on accept, load head → ONE.
- ONE:
  - accept && pop: reload head, stay ONE.
  - accept && !pop: load skid → FULL.
  - pop only: → EMPTY.
- FULL: in_ready=0. On pop, skid moves to head and skid clears → ONE. Otherwise hold.
- in_ready = !skid_valid.
- flush (highest priority): next cycle out_valid=0, skid_valid=0, in_ready=1. An accept in the same cycle is discarded; its sel does not set sel_err.
- Data fields are not cleared by flush; only valids are.
- sel_err: set on any accepted out-of-range select, held until err_clr. If err_clr and a new error occur in the same cycle, set wins.
- out_data/out_sel are stable while out_valid && !out_ready.

## Timing
- Reset (async assert, sync release): out_data=0, out_sel=0, out_valid=0, skid cleared, in_ready=1, sel_err=0.
- Latency: accept in cycle N → out_valid in N+1. No combinational path from inputs to any output.
- Throughput: 1 transfer/cycle while out_ready=1.
- Back-pressure: first stall cycle absorbs one more beat into skid. in_ready drops the following cycle and rises the cycle after the pop.
- Reset asserted mid-transfer: all entries lost immediately, outputs at reset values asynchronously.

## Test plan
- Reset: rst_n=0 with in_valid=1 → out_valid=0, in_ready=1, out_data=0, sel_err=0. Release → first accept (sel=2, ch2=5'h15) gives out_data=5'h15, out_sel=2 one cycle later.
- Streaming: out_ready=1, sel cycling 0..3 with ch_i=i+1 → out_data 1,2,3,4 on consecutive cycles; in_ready stays 1.
- Back-pressure: stream with out_ready=0 for 3 cycles → exactly 2 beats held, in_ready=0 from second stall cycle. Release → beats emerge in order, none lost or duplicated.
- Out-of-range: NUM_IN=3, sel=3, ch0=5'h0A → out_data=5'h0A, out_sel=0, sel_err=1 sticky. err_clr → 0 next cycle. err_clr concurrent with new bad sel → stays 1.
- Flush while FULL with in_valid=1 → next cycle out_valid=0, in_ready=1. The flushed input never appears.
- Parameter sweep: WIDTH=32, NUM_IN=2 and WIDTH=5, NUM_IN=8 → random valid/ready traffic matches scoreboard model.

Source files
------------

// File: rtl/mux_pipe_if.sv
// Handshake bundle for mux_pipe_stage: upstream channel offer, downstream
// registered head entry, and the flush / select-error sideband.
interface mux_pipe_if #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic [NUM_IN*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]        sel;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_sel;
  logic                    out_valid;
  logic                    out_ready;
  logic                    flush;
  logic                    sel_err;
  logic                    err_clr;

  // The stage itself.
  modport slave (
    input  data_in, sel, in_valid, out_ready, flush, err_clr,
    output in_ready, out_data, out_sel, out_valid, sel_err
  );

  // Whatever surrounds the stage: upstream producer plus downstream consumer.
  modport master (
    output data_in, sel, in_valid, out_ready, flush, err_clr,
    input  in_ready, out_data, out_sel, out_valid, sel_err
  );
endinterface

// File: rtl/mux_pipe_stage.sv
// N-way registered select stage with a one-entry skid buffer, valid/ready on
// both sides, synchronous flush and a sticky out-of-range select flag.
module mux_pipe_stage #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  mux_pipe_if.slave  bus
);

  // Occupancy encoded as {out_valid, skid_valid}; 2'b01 cannot occur.
  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

  logic [WIDTH-1:0] head_data;
  logic [SEL_W-1:0] head_sel;
  logic             head_valid;
  logic [WIDTH-1:0] skid_data;
  logic [SEL_W-1:0] skid_sel;
  logic             skid_valid;
  logic             sel_err_q;

  logic [WIDTH-1:0] mux_data;
  logic [SEL_W-1:0] eff_sel;
  logic             sel_bad;
  logic             accept;
  logic             pop;
  logic [1:0]       state;

  // An out-of-range select falls back to channel 0 and reports index 0.
  always_comb begin
    mux_data = bus.data_in[0 +: WIDTH];
    eff_sel  = '0;
    sel_bad  = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(bus.sel) == i) begin
        mux_data = bus.data_in[i*WIDTH +: WIDTH];
        eff_sel  = bus.sel;
        sel_bad  = 1'b0;
      end
    end
  end

  assign accept = bus.in_valid && !skid_valid;
  assign pop    = head_valid && bus.out_ready;
  assign state  = {head_valid, skid_valid};

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would let head see this edge's skid update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data  <= '0;
      head_sel   <= '0;
      head_valid <= 1'b0;
      skid_data  <= '0;
      skid_sel   <= '0;
      skid_valid <= 1'b0;
    end else if (bus.flush) begin
      // Data fields are left as-is; only occupancy is squashed.
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            head_data  <= mux_data;
            head_sel   <= eff_sel;
            head_valid <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && pop) begin
            head_data <= mux_data;
            head_sel  <= eff_sel;
          end else if (accept) begin
            skid_data  <= mux_data;
            skid_sel   <= eff_sel;
            skid_valid <= 1'b1;
          end else if (pop) begin
            head_valid <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            head_data  <= skid_data;
            head_sel   <= skid_sel;
            skid_valid <= 1'b0;
          end
        end
        default: begin
          head_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  // Set beats clear when both happen; flushed beats never count as accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else if (accept && sel_bad && !bus.flush) begin
      sel_err_q <= 1'b1;
    end else if (bus.err_clr) begin
      sel_err_q <= 1'b0;
    end
  end

  assign bus.in_ready  = !skid_valid;
  assign bus.out_data  = head_data;
  assign bus.out_sel   = head_sel;
  assign bus.out_valid = head_valid;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_mux_pipe_stage.sv
// Directed checks of mux_pipe_stage (4- and 3-way) plus scoreboarded random
// traffic on 32-bit/2-way and 5-bit/8-way instances.
module tb_mux_pipe_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_sweep = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mux_pipe_if #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) bus ();
  mux_pipe_if #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) bus3 ();

  mux_pipe_stage #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  mux_pipe_stage #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_sweep
    localparam int SW = (gi == 0) ? 32 : 5;
    localparam int SN = (gi == 0) ? 2 : 8;
    localparam int SS = (gi == 0) ? 1 : 3;

    typedef struct {
      logic [SW-1:0] d;
      logic [SS-1:0] s;
    } beat_t;

    beat_t q[$];
    beat_t b;
    logic  done = 1'b0;

    mux_pipe_if #(.WIDTH(SW), .NUM_IN(SN), .SEL_W(SS)) sbus ();
    mux_pipe_stage #(.WIDTH(SW), .NUM_IN(SN), .SEL_W(SS)) u_sweep (
      .clk(clk), .rst_n(rst_n), .bus(sbus)
    );

    initial begin
      sbus.data_in = '0; sbus.sel = '0; sbus.in_valid = 1'b0;
      sbus.out_ready = 1'b0; sbus.flush = 1'b0; sbus.err_clr = 1'b0;
      wait (start_sweep);
      @(negedge clk);
      for (int c = 0; c < 400; c++) begin
        for (int i = 0; i < SN; i++) sbus.data_in[i*SW +: SW] = SW'($urandom);
        sbus.sel       = SS'($urandom_range(0, SN - 1));
        sbus.in_valid  = (c < 360) ? 1'($urandom_range(0, 1)) : 1'b0;
        sbus.out_ready = (c < 360) ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (sbus.out_valid && sbus.out_ready) begin
          if (q.size() == 0) begin
            check("sweep_spurious_out", 1, 0);
          end else begin
            b = q.pop_front();
            check($sformatf("sweep%0d_data", gi), 64'(sbus.out_data), 64'(b.d));
            check($sformatf("sweep%0d_sel", gi), 64'(sbus.out_sel), 64'(b.s));
          end
        end
        if (sbus.in_valid && sbus.in_ready) begin
          b.s = sbus.sel;
          b.d = sbus.data_in[int'(sbus.sel)*SW +: SW];
          q.push_back(b);
        end
        @(negedge clk);
      end
      check($sformatf("sweep%0d_drained", gi), 64'(sbus.out_valid), 0);
      check($sformatf("sweep%0d_err", gi), 64'(sbus.sel_err), 0);
      done = 1'b1;
    end
  end

  initial begin
    bus.data_in = {5'h00, 5'h15, 5'h00, 5'h00};
    bus.sel = 2'd2; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.flush = 1'b0; bus.err_clr = 1'b0;
    bus3.data_in = {5'h0C, 5'h0B, 5'h0A};
    bus3.sel = 2'd0; bus3.in_valid = 1'b0; bus3.out_ready = 1'b1;
    bus3.flush = 1'b0; bus3.err_clr = 1'b0;

    // Reset with a live offer.
    tick(); tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_sel", bus.out_sel, 0);
    check("rst_sel_err", bus.sel_err, 0);
    rst_n = 1'b1;
    tick();
    check("first_valid", bus.out_valid, 1);
    check("first_data", bus.out_data, 5'h15);
    check("first_sel", bus.out_sel, 2);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("first_popped", bus.out_valid, 0);

    // Streaming at full rate.
    bus.data_in = {5'd4, 5'd3, 5'd2, 5'd1};
    for (int k = 0; k < 4; k++) begin
      bus.sel = 2'(k); bus.in_valid = 1'b1;
      tick();
      check($sformatf("stream%0d_data", k), bus.out_data, k + 1);
      check($sformatf("stream%0d_valid", k), bus.out_valid, 1);
      check($sformatf("stream%0d_ready", k), bus.in_ready, 1);
    end
    bus.in_valid = 1'b0;
    tick();
    check("stream_end", bus.out_valid, 0);

    // Back-pressure: three stalled cycles hold exactly two beats.
    bus.sel = 2'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    check("bp_head", bus.out_data, 1);
    bus.out_ready = 1'b0; bus.sel = 2'd1;
    tick();
    check("bp_stall1_ready", bus.in_ready, 0);
    check("bp_stall1_data", bus.out_data, 1);
    bus.sel = 2'd2;
    tick();
    check("bp_stall2_ready", bus.in_ready, 0);
    tick();
    check("bp_stall3_ready", bus.in_ready, 0);
    check("bp_stall3_data", bus.out_data, 1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_rel1_data", bus.out_data, 2);
    check("bp_rel1_ready", bus.in_ready, 1);
    tick();
    check("bp_rel2_data", bus.out_data, 3);
    check("bp_rel2_valid", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    tick();
    check("bp_drained", bus.out_valid, 0);

    // Flush while FULL with a concurrent offer.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.sel = 2'd0;
    tick();
    bus.sel = 2'd1;
    tick();
    check("fl_full", bus.in_ready, 0);
    bus.flush = 1'b1; bus.sel = 2'd3;
    tick();
    check("fl_out_valid", bus.out_valid, 0);
    check("fl_in_ready", bus.in_ready, 1);
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    tick();
    check("fl_no_ghost", bus.out_valid, 0);

    // Out-of-range select on the 3-way instance.
    bus3.sel = 2'd3; bus3.in_valid = 1'b1;
    tick();
    check("oor_data", bus3.out_data, 5'h0A);
    check("oor_sel", bus3.out_sel, 0);
    check("oor_err", bus3.sel_err, 1);
    bus3.in_valid = 1'b0;
    tick();
    check("oor_sticky", bus3.sel_err, 1);
    bus3.err_clr = 1'b1;
    tick();
    check("oor_cleared", bus3.sel_err, 0);
    bus3.in_valid = 1'b1;
    tick();
    check("oor_set_wins", bus3.sel_err, 1);
    bus3.in_valid = 1'b0;
    tick();
    check("oor_clear2", bus3.sel_err, 0);
    bus3.err_clr = 1'b0; bus3.flush = 1'b1; bus3.in_valid = 1'b1;
    tick();
    check("oor_flush_no_err", bus3.sel_err, 0);
    check("oor_flush_valid", bus3.out_valid, 0);
    bus3.flush = 1'b0; bus3.sel = 2'd2;
    tick();
    check("oor_inrange_data", bus3.out_data, 5'h0C);
    check("oor_inrange_sel", bus3.out_sel, 2);
    bus3.in_valid = 1'b0;

    // Asynchronous reset while holding a beat.
    bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.sel = 2'd3;
    tick();
    check("mid_loaded", bus.out_data, 4);
    bus.in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.out_valid, 0);
    check("mid_rst_data", bus.out_data, 0);
    check("mid_rst_ready", bus.in_ready, 1);
    #1 rst_n = 1'b1;
    tick();
    check("mid_rst_idle", bus.out_valid, 0);

    // Random traffic on the parameter-sweep instances.
    start_sweep = 1'b1;
    for (int c = 0; c < 2000 && !(g_sweep[0].done && g_sweep[1].done); c++) @(posedge clk);
    check("sweep_done", {g_sweep[0].done, g_sweep[1].done}, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
